// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, FSM states and flag indices for the ALU command sequencer
// Purpose: single source for the ALU opcode map, sequencer state encoding and
//          response flag bit positions used by the sequencer and its register file.
// Ports:   none (package).
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD        = 4'b0000;
  localparam logic [3:0] OP_SUB        = 4'b0001;
  localparam logic [3:0] OP_INC        = 4'b0010;
  localparam logic [3:0] OP_DEC        = 4'b0011;
  localparam logic [3:0] OP_AND        = 4'b0100;
  localparam logic [3:0] OP_OR         = 4'b0101;
  localparam logic [3:0] OP_XOR        = 4'b0110;
  localparam logic [3:0] OP_SHL        = 4'b0111;
  localparam logic [3:0] OP_SHR        = 4'b1000;
  localparam logic [3:0] OP_NOT        = 4'b1001;
  localparam logic [3:0] OP_LAST_LEGAL = OP_NOT;

  localparam int FLAGS_W    = 4;
  localparam int FLG_CARRY  = 3;
  localparam int FLG_ZERO   = 2;
  localparam int FLG_SIGN   = 1;
  localparam int FLG_PARITY = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RES,
    ST_WAIT_FLAG,
    ST_RESP
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

  // Only the arithmetic group produces a meaningful carry/borrow; the
  // logic and shift group reports carry as 0 regardless of the ALU pin.
  function automatic logic op_has_carry(input logic [3:0] op);
    return op < OP_AND;
  endfunction

endpackage

// File: rtl/alu_seq_rf.sv
// rtl/alu_seq_rf.sv - register file with two async read ports and a prioritised write port
// Purpose: DEPTH x DATA_W operand store. Writeback from the sequencer and the
//          external preload port share one synchronous write; writeback wins
//          when both target the same entry in the same cycle.
// Ports:   clk, reset (async, active-high clear of all entries)
//          ra_addr/ra_data, rb_addr/rb_data : asynchronous read ports
//          wb_en/wb_addr/wb_data            : sequencer writeback (high priority)
//          ext_en/ext_addr/ext_data         : external preload (low priority)
module alu_seq_rf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ext_en,
  input  logic [AW-1:0]     ext_addr,
  input  logic [DATA_W-1:0] ext_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_en && (wb_addr == AW'(i))) begin
          mem[i] <= wb_data;
        end else if (ext_en && (ext_addr == AW'(i))) begin
          mem[i] <= ext_data;
        end
      end
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command-driven initiator for an external registered ALU
// Purpose: accepts one ALU command at a time, fetches operands from the local
//          register file, holds the ALU inputs across the ALU's result and flag
//          latency, captures result and flags, writes the result back and
//          returns a response.
// Ports:   clk, reset (async, active-high)
//          cmd_valid/cmd_ready/cmd_op/cmd_rd/cmd_ra/cmd_rb : command handshake
//          wr_en/wr_addr/wr_data                           : external RF preload
//          alu_op_code/alu_a/alu_b                         : to ALU inputs
//          alu_q/alu_carry/alu_zero/alu_parity             : from ALU outputs
//          rsp_valid/rsp_ready/rsp_data/rsp_flags/rsp_err  : response handshake
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int RF_DEPTH = 8,
  localparam int AW      = $clog2(RF_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [AW-1:0]      cmd_rd,
  input  logic [AW-1:0]      cmd_ra,
  input  logic [AW-1:0]      cmd_rb,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic [3:0]         alu_op_code,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_q,
  input  logic               alu_carry,
  input  logic               alu_zero,
  input  logic               alu_parity,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic [FLAGS_W-1:0] rsp_flags,
  output logic               rsp_err
);

  state_t               state;
  state_t               state_next;
  logic [AW-1:0]        rd_q;
  logic                 carry_q;
  logic [DATA_W-1:0]    rf_a;
  logic [DATA_W-1:0]    rf_b;
  logic                 wb_en;
  logic [FLAGS_W-1:0]   flags_next;

  // Operands are read with the command's own addresses while in IDLE and
  // registered onto alu_a/alu_b at the accept edge, so later external writes
  // to ra/rb cannot disturb an operation already in flight.
  alu_seq_rf #(
    .DATA_W (DATA_W),
    .DEPTH  (RF_DEPTH)
  ) u_rf (
    .clk      (clk),
    .reset    (reset),
    .ra_addr  (cmd_ra),
    .ra_data  (rf_a),
    .rb_addr  (cmd_rb),
    .rb_data  (rf_b),
    .wb_en    (wb_en),
    .wb_addr  (rd_q),
    .wb_data  (alu_q),
    .ext_en   (wr_en),
    .ext_addr (wr_addr),
    .ext_data (wr_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    wb_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        // Held low while reset is asserted even though the state already reads IDLE.
        cmd_ready = !reset;
        if (cmd_valid) begin
          state_next = op_is_legal(cmd_op) ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE:     state_next = ST_WAIT_RES;
      ST_WAIT_RES:  state_next = ST_WAIT_FLAG;
      ST_WAIT_FLAG: begin
        wb_en      = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Carry was captured one cycle earlier; zero/parity come straight from the
  // ALU and sign is taken from the result MSB here.
  always_comb begin
    flags_next             = '0;
    flags_next[FLG_CARRY]  = op_has_carry(alu_op_code) ? carry_q : 1'b0;
    flags_next[FLG_ZERO]   = alu_zero;
    flags_next[FLG_SIGN]   = alu_q[DATA_W-1];
    flags_next[FLG_PARITY] = alu_parity;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q        <= '0;
      carry_q     <= 1'b0;
      alu_op_code <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_data    <= '0;
      rsp_flags   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            rd_q <= cmd_rd;
            if (op_is_legal(cmd_op)) begin
              alu_op_code <= cmd_op;
              alu_a       <= rf_a;
              alu_b       <= rf_b;
            end else begin
              // rsp_data/rsp_flags are already zero whenever the FSM is idle.
              rsp_err <= 1'b1;
            end
          end
        end
        ST_WAIT_RES: begin
          carry_q <= alu_carry;
        end
        ST_WAIT_FLAG: begin
          rsp_data    <= alu_q;
          rsp_flags   <= flags_next;
          alu_op_code <= '0;
          alu_a       <= '0;
          alu_b       <= '0;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
